// File: rtl/bram_frame_reader_if.sv
// Bundle of the descriptor, BRAM port B and AXI4-Stream signals of the frame reader.
// The master modport is the reader itself; the slave modport is its environment.
interface bram_frame_reader_if #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 1600,
    parameter int LEN_WIDTH = 14
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int DW = NB_COL * COL_WIDTH;

    logic                 desc_valid_i;
    logic                 desc_ready_o;
    logic [AW-1:0]        desc_addr_i;
    logic [LEN_WIDTH-1:0] desc_len_i;

    logic [AW-1:0]        bram_addr_o;
    logic                 bram_en_o;
    logic                 bram_regce_o;
    logic                 bram_rst_o;
    logic [DW-1:0]        bram_dout_i;

    logic [DW-1:0]        m_axis_tdata_o;
    logic [NB_COL-1:0]    m_axis_tkeep_o;
    logic                 m_axis_tlast_o;
    logic                 m_axis_tvalid_o;
    logic                 m_axis_tready_i;

    logic                 frame_done_o;

    modport master (
        input  desc_valid_i, desc_addr_i, desc_len_i, bram_dout_i, m_axis_tready_i,
        output desc_ready_o, bram_addr_o, bram_en_o, bram_regce_o, bram_rst_o,
        output m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o, m_axis_tvalid_o, frame_done_o
    );

    modport slave (
        output desc_valid_i, desc_addr_i, desc_len_i, bram_dout_i, m_axis_tready_i,
        input  desc_ready_o, bram_addr_o, bram_en_o, bram_regce_o, bram_rst_o,
        input  m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o, m_axis_tvalid_o, frame_done_o
    );
endinterface

// File: rtl/bram_frame_reader.sv
// Frame buffer reader: walks a ring of BRAM words for each descriptor and
// streams them out as AXI4-Stream. Read latency is absorbed by a small prefetch
// FIFO; reads are only issued while the FIFO plus in-flight reads have room, so
// the FIFO can never overflow and no read is lost or repeated.
module bram_frame_reader #(
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8,
    parameter int RAM_DEPTH  = 1600,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bram_frame_reader_if.master bus
);
    localparam int AW   = $clog2(RAM_DEPTH);
    localparam int DW   = NB_COL * COL_WIDTH;
    localparam int CW   = $clog2(NB_COL);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
    localparam int EW   = DW + NB_COL + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next;
    logic [AW-1:0]          addr_r;
    logic                   en_r;
    logic                   en_next;
    logic [LEN_WIDTH-1:0]   words_left_r;
    logic [LEN_WIDTH-1:0]   words_after_s;
    logic [CW-1:0]          tail_r;
    logic [RD_LATENCY-1:0]  vld_sr_r;
    logic [RD_LATENCY-1:0]  last_sr_r;
    logic [EW-1:0]          fifo_mem_r [0:FIFO_DEPTH-1];
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [CNTW-1:0]        count_r;
    logic                   done_r;
    logic                   done_next;

    logic                   accept_s;
    logic                   len_zero_s;
    logic [LEN_WIDTH:0]     len_ext_s;
    logic [LEN_WIDTH-1:0]   words_s;
    logic                   last_issue_s;
    logic [OW-1:0]          inflight_s;
    logic [OW-1:0]          occ_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   push_last_s;
    logic [EW-1:0]          push_word_s;
    logic [EW-1:0]          head_s;
    logic                   head_last_s;
    logic                   tvalid_s;

    // Byte qualifier of the final beat: the lowest 'tail' lanes, or all lanes when tail is zero.
    function automatic logic [NB_COL-1:0] keep_mask(input logic [CW-1:0] tail);
        logic [NB_COL-1:0] m;
        m = '1;
        if (tail != '0) begin
            for (int i = 0; i < NB_COL; i++) begin
                m[i] = (i < int'(tail));
            end
        end else begin
            m = '1;
        end
        return m;
    endfunction

    // Circular pointer increment for the prefetch FIFO.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign len_zero_s   = (bus.desc_len_i == '0);
    assign len_ext_s    = {1'b0, bus.desc_len_i} + (LEN_WIDTH + 1)'(NB_COL - 1);
    assign words_s      = LEN_WIDTH'(len_ext_s >> CW);
    assign last_issue_s = (words_left_r == LEN_WIDTH'(1));

    assign tvalid_s     = (count_r != '0);
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign head_last_s  = head_s[EW-1];
    assign pop_s        = tvalid_s & bus.m_axis_tready_i;
    assign push_s       = vld_sr_r[RD_LATENCY-1];
    assign push_last_s  = last_sr_r[RD_LATENCY-1];
    assign push_word_s  = {push_last_s,
                           push_last_s ? keep_mask(tail_r) : {NB_COL{1'b1}},
                           bus.bram_dout_i};

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next state, descriptor acceptance and frame-done request.
    always_comb begin
        state_next = state_r;
        accept_s   = 1'b0;
        done_next  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.desc_valid_i) begin
                    accept_s = 1'b1;
                    if (len_zero_s) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = ISSUE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                if (en_r && last_issue_s) begin
                    state_next = DRAIN;
                end else begin
                    state_next = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && head_last_s) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Credit check for the next cycle's read: occupancy after this edge must leave a free slot.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + OW'(vld_sr_r[i]);
        end
        occ_s         = OW'(count_r) + inflight_s + OW'(en_r) - OW'(pop_s);
        words_after_s = en_r ? (words_left_r - LEN_WIDTH'(1)) : words_left_r;
        if (accept_s && !len_zero_s) begin
            en_next = 1'b1;
        end else if ((state_r == ISSUE) && (words_after_s != '0) && (occ_s < OW'(FIFO_DEPTH))) begin
            en_next = 1'b1;
        end else begin
            en_next = 1'b0;
        end
    end

    // Read issue: address ring walk, remaining word count and read-valid/last pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_r       <= '0;
            en_r         <= 1'b0;
            words_left_r <= '0;
            tail_r       <= '0;
            vld_sr_r     <= '0;
            last_sr_r    <= '0;
            done_r       <= 1'b0;
        end else begin
            en_r      <= en_next;
            done_r    <= done_next;
            vld_sr_r  <= RD_LATENCY'({vld_sr_r, en_r});
            last_sr_r <= RD_LATENCY'({last_sr_r, en_r & last_issue_s});
            if (accept_s) begin
                addr_r       <= bus.desc_addr_i;
                words_left_r <= words_s;
                tail_r       <= bus.desc_len_i[CW-1:0];
            end else if (en_r) begin
                addr_r       <= (addr_r == AW'(RAM_DEPTH - 1)) ? '0 : addr_r + AW'(1);
                words_left_r <= words_left_r - LEN_WIDTH'(1);
            end
        end
    end

    // Prefetch FIFO: push on read-pipeline exit, pop on stream handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_word_s;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.desc_ready_o    = (state_r == IDLE);
    assign bus.bram_addr_o     = addr_r;
    assign bus.bram_en_o       = en_r;
    assign bus.bram_regce_o    = 1'b1;
    assign bus.bram_rst_o      = 1'b0;
    assign bus.m_axis_tvalid_o = tvalid_s;
    assign bus.m_axis_tdata_o  = tvalid_s ? head_s[DW-1:0] : '0;
    assign bus.m_axis_tkeep_o  = tvalid_s ? head_s[DW+NB_COL-1:DW] : '0;
    assign bus.m_axis_tlast_o  = tvalid_s & head_last_s;
    assign bus.frame_done_o    = done_r;
endmodule

// File: doc/bram_frame_reader.md
Name: bram_frame_reader

Overview:
- Drains stored Ethernet frames from port B of the byte-enabled frame buffer BRAM and emits them as a 32-bit AXI4-Stream toward the AXI side.
- A descriptor (start word address, byte length) is accepted per frame; the block issues sequential word reads with ring wrap, absorbs the fixed BRAM read latency in a credit-controlled prefetch FIFO, and generates tkeep/tlast from the byte length.
- Read-only peer of the MAC-side writer: top level ties the BRAM port B write enable and data-in to zero.

Parameters:
NB_COL, 4, bytes per BRAM word (power of 2)
COL_WIDTH, 8, bits per byte lane
RAM_DEPTH, 1600, BRAM depth in words; ring wrap point
RD_LATENCY, 2, BRAM read latency in clocks (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY)
FIFO_DEPTH, 4, prefetch FIFO entries; must be >= RD_LATENCY+2
LEN_WIDTH, 14, frame byte-length width
(AW = clogb2(RAM_DEPTH-1), DW = NB_COL*COL_WIDTH)

Ports:
clk_i  in  1  single clock, shared with BRAM port B
rst_i  in  1  reset, asynchronous, active-high
desc_valid_i  in  1  descriptor valid
desc_ready_o  out  1  descriptor ready
desc_addr_i  in  AW  start word address
desc_len_i  in  LEN_WIDTH  frame length in bytes
bram_addr_o  out  AW  BRAM port B address
bram_en_o  out  1  BRAM port B enable (one per read)
bram_regce_o  out  1  BRAM output register enable; constant 1
bram_rst_o  out  1  BRAM output reset; constant 0
bram_dout_i  in  DW  BRAM port B read data
m_axis_tdata_o  out  DW  stream data, byte 0 in bits [7:0]
m_axis_tkeep_o  out  NB_COL  byte qualifiers
m_axis_tlast_o  out  1  last beat of frame
m_axis_tvalid_o  out  1  stream valid
m_axis_tready_i  in  1  stream ready
frame_done_o  out  1  one-cycle pulse when frame completes

Behaviour:
- Reset (async assert, sync release): state IDLE, desc_ready_o=1, bram_en_o=0, bram_addr_o=0, tvalid/tlast/frame_done_o=0, tdata/tkeep=0, FIFO and read-valid pipeline flushed, counters zero.
- States: IDLE, ISSUE, DRAIN.
- IDLE: desc_ready_o=1 only here. On desc_valid_i&desc_ready_o, latch addr; words = ceil(len/NB_COL); tail = len mod NB_COL. len=0 -> stay IDLE, pulse frame_done_o next cycle, no beats. Else -> ISSUE.
- ISSUE: bram_en_o=1 for a cycle iff (fifo_count + inflight) < FIFO_DEPTH. Each issue advances address: RAM_DEPTH-1 -> 0, else +1. After final word issued -> DRAIN.
- Read-valid shift register (RD_LATENCY stages) tracks issued reads; tags the final word. On exit it writes bram_dout_i into FIFO with tkeep and tlast. inflight = set bits in the shift register.
- Credit rule guarantees no FIFO overflow; no read is ever dropped or repeated.
- Stream: tvalid = FIFO non-empty; data/keep/last held stable while tvalid&!tready. Pop on tvalid&tready.
- tkeep = all ones except last beat: lowest tail bits set (tail=0 -> all ones). tlast only on last beat.
- DRAIN: when last beat handshakes -> IDLE; frame_done_o pulses the cycle after. A new descriptor is accepted no earlier than that IDLE cycle.
- Latency: acceptance edge E0; first read issued in cycle after E0; tvalid rises after edge E0+RD_LATENCY+1.
- Throughput: tready held high -> one beat per clock after initial latency, no bubbles.
- Simultaneous FIFO push and pop: count unchanged, both take effect.
- Reset mid-frame: frame is abandoned, outputs return to reset values at once. No partial beats after release.

Test Plan:
- BRAM words 0..1 = 0x03020100, 0x07060504, desc addr=0 len=8, tready=1 -> 2 beats, tkeep=1111 both, tlast on beat 2, tvalid first high 3 edges after acceptance, frame_done_o pulses once.
- len=13 addr=10 -> 4 beats from words 10..13, last tkeep=0001, tlast only on beat 4.
- addr=1599 len=12 -> bram_addr_o sequence 1599, 0, 1, then 3 beats in that order.
- len=64, tready low 10 cycles from beat 3 -> no more than FIFO_DEPTH words buffered or in flight, bram_en_o stalls, 16 beats total with no loss or duplication.
- len=0 -> no tvalid, frame_done_o single pulse, desc_ready_o back high.
- rst_i asserted mid-frame (beat 5 of 16) -> tvalid drops asynchronously. After release, desc addr=100 len=4 -> exactly 1 beat from word 100, tkeep=1111, tlast=1.
